load_store_unit: RTL and testbench

Data-memory access stage of the processor datapath. It accepts one load or store request at a time from the execute stage and runs a req/ack handshake with data memory. It extracts and extends load bytes and presents the 32-bit load result, which drives the memory-data input (select = 1) of the write-back data multiplexer. It also stalls the pipeline while an access is outstanding.

---
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory access stage: one load/store at a time over a req/ack handshake, with
// byte-lane steering, load extension, timeout abort. Optional macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_rd_valid,
  output logic [31:0] o_rd_data,
  output logic        o_stall,
  output logic        o_err
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT_CYC - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_signed;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_rd_valid;
  logic [31:0] r_rd_data;
  logic        r_err;

  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic        w_trap;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld;

  // Offset is the size-aligned byte offset; misaligned low bits are dropped here.
  always_comb begin
    w_off = 2'b00;
    w_be  = 4'b1111;
    case (i_req_size)
      2'b00: begin
        w_off = i_req_addr[1:0];
        w_be  = 4'b0001 << i_req_addr[1:0];
      end
      2'b01: begin
        w_off = {i_req_addr[1], 1'b0};
        w_be  = 4'b0011 << {i_req_addr[1], 1'b0};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = ((i_req_size == 2'b01) && i_req_addr[0]) ||
                  (i_req_size[1] && (i_req_addr[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    case (r_off)
      2'd0:    w_byte = i_mem_rdata[7:0];
      2'd1:    w_byte = i_mem_rdata[15:8];
      2'd2:    w_byte = i_mem_rdata[23:16];
      default: w_byte = i_mem_rdata[31:24];
    endcase
    w_half = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_size)
      2'b00:   w_ld = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ld = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ld = i_mem_rdata;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_size      <= '0;
      r_off       <= '0;
      r_signed    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: if (i_req_valid) begin
          r_size   <= i_req_size;
          r_off    <= w_off;
          r_signed <= i_req_signed;
          r_cnt    <= '0;
          if (w_trap) begin
            r_state <= S_DONE;
            r_err   <= 1'b1;
          end else begin
            r_state     <= S_ACCESS;
            r_mem_req   <= 1'b1;
            r_mem_we    <= i_req_we;
            r_mem_addr  <= {i_req_addr[31:2], 2'b00};
            r_mem_wdata <= i_req_wdata << {w_off, 3'b000};
            r_mem_be    <= w_be;
          end
        end
        S_ACCESS: begin
          // An ack in the timeout cycle still completes normally.
          if (i_mem_ack) begin
            r_state    <= S_DONE;
            r_rd_valid <= 1'b1;
            if (!r_mem_we) r_rd_data <= w_ld;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_be   <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_state   <= S_IDLE;
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_be  <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = (r_state == S_IDLE);
  assign o_stall     = (r_state != S_IDLE);
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_be    = r_mem_be;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_err       = r_err;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand sequences, random vs. reference model.
module tb_load_store_unit;
  localparam int TO = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, mem_ack = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, mem_req, mem_we, rd_valid, stall, err;
  logic [31:0] mem_addr, mem_wdata, rd_data;
  logic [3:0]  mem_be;

  int n_chk = 0, n_fail = 0;
  logic [31:0] m_rd = '0;

  load_store_unit #(.TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_size(req_size), .i_req_signed(req_signed), .o_mem_req(mem_req),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata), .o_rd_valid(rd_valid),
    .o_rd_data(rd_data), .o_stall(stall), .o_err(err));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_chk);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on sizes and offsets.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction
  function automatic int offs(input logic [1:0] sz, input logic [31:0] a);
    int nb = nbytes(sz);
    return (int'(a % 4) / nb) * nb;
  endfunction
  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [31:0] a);
    return 4'(((1 << nbytes(sz)) - 1) << offs(sz, a));
  endfunction
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m = '0;
    for (int j = 0; j < 4; j++) if (be[j]) m[8*j +: 8] = 8'hFF;
    return m;
  endfunction
  function automatic logic [31:0] load_of(input logic [1:0] sz, input logic sg,
                                          input logic [31:0] a, input logic [31:0] rd);
    longint span, v;
    span = longint'(1) << (8 * nbytes(sz));
    v = longint'(rd >> (8 * offs(sz, a))) % span;
    if (sg && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // One complete access; ack arrives in the k-th ACCESS cycle. req_valid is held
  // with scrambled fields while busy to show the latched request is kept.
  task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] sz, input logic sg, input logic [31:0] rd,
                           input int k, input string tg,
                           output logic [31:0] seen_addr, output logic [3:0] seen_be);
    logic [31:0] ea, msk;
    logic [3:0]  eb;
    int st;
    ea  = a - (a % 4);
    eb  = be_of(sz, a);
    msk = lane_mask(eb);
    st  = 0;
    seen_addr = '0;
    seen_be   = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_signed = sg;
    @(posedge clk); #1;
    req_addr = $urandom; req_wdata = $urandom; req_we = ~we; req_size = 2'($urandom);
    for (int i = 1; i <= k; i++) begin
      if (i == 1) begin seen_addr = mem_addr; seen_be = mem_be; end
      chk({tg, " mem_req"}, 32'(mem_req), 32'd1);
      chk({tg, " mem_addr"}, mem_addr, ea);
      chk({tg, " mem_be"}, 32'(mem_be), 32'(eb));
      chk({tg, " mem_we"}, 32'(mem_we), 32'(we));
      chk({tg, " req_ready"}, 32'(req_ready), 32'd0);
      if (we) chk({tg, " mem_wdata"}, mem_wdata & msk, (wd << (8 * offs(sz, a))) & msk);
      st += int'(stall);
      if (i == k) begin mem_ack = 1'b1; mem_rdata = rd; end
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rdata = $urandom;
    end
    req_valid = 1'b0;
    if (!we) m_rd = load_of(sz, sg, a, rd);
    chk({tg, " rd_valid"}, 32'(rd_valid), 32'd1);
    chk({tg, " err"}, 32'(err), 32'd0);
    chk({tg, " rd_data"}, rd_data, m_rd);
    chk({tg, " done mem_req"}, 32'(mem_req), 32'd0);
    chk({tg, " done mem_be"}, 32'(mem_be), 32'd0);
    st += int'(stall);
    @(posedge clk); #1;
    chk({tg, " req_ready"}, 32'(req_ready), 32'd1);
    chk({tg, " rd_valid end"}, 32'(rd_valid), 32'd0);
    chk({tg, " stall cycles"}, 32'(st + int'(stall)), 32'(k + 1));
  endtask

  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata; logic [1:0] sz; logic sg;
    logic [31:0] rdata; int k; logic [31:0] eaddr; logic [3:0] ebe; logic [31:0] erd;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [31:0] sa, a;
    logic [3:0]  sb;
    logic [1:0]  sz;
    int n;

    tbl.push_back('{1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 3, 32'h100, 4'b1111, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 32'h80123456, 1, 32'h100, 4'b1000, 32'hFFFFFF80});
    tbl.push_back('{1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 32'h80123456, 2, 32'h100, 4'b1100, 32'h00008012});
    tbl.push_back('{1'b1, 32'h206, 32'h0000ABCD, 2'b01, 1'b0, 32'h0, 1, 32'h204, 4'b1100, 32'h00008012});
    tbl.push_back('{1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 32'h80007FFF, TO, 32'h100, 4'b1100, 32'hFFFF8000});
    tbl.push_back('{1'b1, 32'h3, 32'h5A, 2'b00, 1'b0, 32'h0, 2, 32'h0, 4'b1000, 32'hFFFF8000});
    tbl.push_back('{1'b0, 32'h101, 32'h0, 2'b00, 1'b0, 32'h0000A500, 2, 32'h100, 4'b0010, 32'h000000A5});
    tbl.push_back('{1'b0, 32'h300, 32'h0, 2'b11, 1'b1, 32'h12345678, 1, 32'h300, 4'b1111, 32'h12345678});
`ifndef LSU_MISALIGN_TRAP_EN
    tbl.push_back('{1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 32'h11223344, 1, 32'h100, 4'b1111, 32'h11223344});
`endif

    // Reset state
    #12;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_be", 32'(mem_be), 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset err", 32'(err), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i]) begin
      do_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sz, tbl[i].sg, tbl[i].rdata,
                tbl[i].k, $sformatf("vec%0d", i), sa, sb);
      chk($sformatf("vec%0d addr", i), sa, tbl[i].eaddr);
      chk($sformatf("vec%0d be", i), 32'(sb), 32'(tbl[i].ebe));
      chk($sformatf("vec%0d rd_data held", i), rd_data, tbl[i].erd);
    end

    // Stray ack while idle
    @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1; mem_ack = 1'b0;
    chk("stray rd_valid", 32'(rd_valid), 32'd0);
    chk("stray req_ready", 32'(req_ready), 32'd1);
    chk("stray rd_data", rd_data, m_rd);

    // Timeout: no ack ever
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_size = 2'b10;
    @(posedge clk); #1; req_valid = 1'b0;
    n = 0;
    while (mem_req && n < 20) begin n++; @(posedge clk); #1; end
    chk("timeout mem_req cycles", 32'(n), 32'(TO));
    chk("timeout err", 32'(err), 32'd1);
    chk("timeout rd_valid", 32'(rd_valid), 32'd0);
    chk("timeout req_ready", 32'(req_ready), 32'd1);
    chk("timeout rd_data", rd_data, m_rd);
    @(posedge clk); #1;
    chk("timeout err pulse", 32'(err), 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h101; req_size = 2'b10;
    @(posedge clk); #1; req_valid = 1'b0;
    chk("trap mem_req", 32'(mem_req), 32'd0);
    chk("trap err", 32'(err), 32'd1);
    chk("trap rd_valid", 32'(rd_valid), 32'd0);
    chk("trap stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("trap req_ready", 32'(req_ready), 32'd1);
    chk("trap err pulse", 32'(err), 32'd0);
    chk("trap rd_data", rd_data, m_rd);
`endif

    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      a = a - (a % nbytes(sz));
`endif
      do_access(1'($urandom), a, $urandom, sz, 1'($urandom), $urandom,
                $urandom_range(1, TO), $sformatf("rnd%0d", i), sa, sb);
    end

    // Reset in the middle of an access
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h80; req_size = 2'b10;
    @(posedge clk); #1; req_valid = 1'b0;
    chk("midrst pre mem_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst mem_req async", 32'(mem_req), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd1);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst req_ready", 32'(req_ready), 32'd1);
    chk("post rst stall", 32'(stall), 32'd0);
    chk("post rst mem_req", 32'(mem_req), 32'd0);
    chk("post rst mem_we", 32'(mem_we), 32'd0);
    chk("post rst mem_addr", mem_addr, 32'd0);
    chk("post rst mem_wdata", mem_wdata, 32'd0);
    chk("post rst mem_be", 32'(mem_be), 32'd0);
    chk("post rst rd_data", rd_data, 32'd0);
    chk("post rst rd_valid", 32'(rd_valid), 32'd0);
    chk("post rst err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
